// File: rtl/image_frame_loader.sv
// rtl/image_frame_loader.sv - byte stream to 24-bit RGB frame-memory writer
// Optional LOADER_CHECKSUM_EN: trailing checksum byte per frame, adds csum_err.
module image_frame_loader #(
    parameter int HVID   = 640,
    parameter int VVID   = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk_25,
    input  logic              rst,
    input  logic              load_en,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_sof,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [23:0]       mem_wdata,
    output logic              busy,
    output logic              frame_done,
`ifdef LOADER_CHECKSUM_EN
    output logic              csum_err,
`endif
    output logic              sof_err
);

    localparam int FRAME_PIXELS = HVID * VVID;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIXELS - 1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD} state_t;
`endif

    state_t              state_q, state_d;
    logic [1:0]          phase_q, phase_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [7:0]          r_q, r_d, g_q, g_d;
    logic                we_d, done_d, sof_err_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [23:0]         wdata_d;
    logic                acc, restart;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
    logic                csum_err_d;
`endif

    assign s_ready = load_en;
    assign acc     = s_valid && load_en;
    assign busy    = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        r_d       = r_q;
        g_d       = g_q;
        we_d      = 1'b0;
        addr_d    = mem_addr;
        wdata_d   = mem_wdata;
        done_d    = 1'b0;
        sof_err_d = 1'b0;
        restart   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        csum_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (acc && s_sof) restart = 1'b1;
            end
            LOAD: begin
                if (acc && s_sof) begin
                    restart   = 1'b1;
                    sof_err_d = 1'b1;
                end else if (acc) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q + s_data;
`endif
                    case (phase_q)
                        2'd1: begin
                            g_d     = s_data;
                            phase_d = 2'd2;
                        end
                        2'd2: begin
                            we_d    = 1'b1;
                            addr_d  = idx_q;
                            wdata_d = {r_q, g_q, s_data};
                            phase_d = 2'd0;
                            if (idx_q == LAST_IDX) begin
                                idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
                                state_d = CSUM;
`else
                                state_d = IDLE;
                                done_d  = 1'b1;
`endif
                            end else begin
                                idx_d = idx_q + ADDR_W'(1);
                            end
                        end
                        default: begin
                            r_d     = s_data;
                            phase_d = 2'd1;
                        end
                    endcase
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (acc && s_sof) begin
                    restart   = 1'b1;
                    sof_err_d = 1'b1;
                end else if (acc) begin
                    done_d     = 1'b1;
                    csum_err_d = (s_data != csum_q);
                    state_d    = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // An SOF byte always becomes R of pixel 0; any partial pixel is dropped.
        if (restart) begin
            state_d = LOAD;
            r_d     = s_data;
            phase_d = 2'd1;
            idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = s_data;
`endif
        end
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= 2'd0;
            idx_q      <= '0;
            r_q        <= 8'd0;
            g_q        <= 8'd0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 24'd0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
            csum_err   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            r_q        <= r_d;
            g_q        <= g_d;
            mem_we     <= we_d;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
            frame_done <= done_d;
            sof_err    <= sof_err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            csum_err   <= csum_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_image_frame_loader.sv
// tb/tb_image_frame_loader.sv - directed bench for image_frame_loader (small 8x4 frame)
module tb_image_frame_loader;

    localparam int HV = 8;
    localparam int VV = 4;
    localparam int AW = 5;
    localparam int FP = HV * VV;

    logic          clk_25 = 1'b0;
    logic          rst = 1'b1;
    logic          load_en = 1'b0;
    logic [7:0]    s_data = 8'd0;
    logic          s_valid = 1'b0;
    logic          s_sof = 1'b0;
    logic          s_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_wdata;
    logic          busy;
    logic          frame_done;
    logic          sof_err;
`ifdef LOADER_CHECKSUM_EN
    logic          csum_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wr_addr[$];
    logic [23:0]   wr_data[$];
    int            done_cnt = 0;
    int            sof_cnt = 0;
    logic          done_we = 1'b0;
    logic          done_busy = 1'b1;
    logic          done_cerr = 1'b1;
    logic [AW-1:0] done_addr = '0;

    image_frame_loader #(.HVID(HV), .VVID(VV), .ADDR_W(AW)) dut (
        .clk_25     (clk_25),
        .rst        (rst),
        .load_en    (load_en),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_sof      (s_sof),
        .s_ready    (s_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .frame_done (frame_done),
`ifdef LOADER_CHECKSUM_EN
        .csum_err   (csum_err),
`endif
        .sof_err    (sof_err)
    );

    always #20 clk_25 = ~clk_25;

    always @(negedge clk_25) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
        if (frame_done) begin
            done_cnt++;
            done_we   = mem_we;
            done_addr = mem_addr;
            done_busy = busy;
`ifdef LOADER_CHECKSUM_EN
            done_cerr = csum_err;
`endif
        end
        if (sof_err) sof_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit sof, input bit rnd);
        while (rnd && $urandom_range(0, 1) == 0) begin
            load_en = 1'b0; s_valid = 1'b1; s_data = d; s_sof = sof;
            @(negedge clk_25);
        end
        load_en = 1'b1; s_valid = 1'b1; s_data = d; s_sof = sof;
        @(negedge clk_25);
        s_valid = 1'b0; s_sof = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk_25);
        #1;
    endtask

    task automatic send_frame(input bit rnd);
        logic [15:0] kk;
        logic [7:0]  sum;
        sum = 8'd0;
        for (int k = 0; k < FP; k++) begin
            kk = 16'(k);
            send(kk[7:0], k == 0, rnd);
            send(kk[15:8], 1'b0, rnd);
            send(8'hA5, 1'b0, rnd);
            sum = sum + kk[7:0] + kk[15:8] + 8'hA5;
        end
`ifdef LOADER_CHECKSUM_EN
        send(sum, 1'b0, rnd);
`endif
    endtask

    task automatic check_frame(input string tag, input int base, input int db);
        logic [15:0] kk;
        check({tag, "_nwrites"}, 32'(wr_addr.size() - base), 32'(FP));
        for (int k = 0; k < FP && base + k < wr_addr.size(); k++) begin
            kk = 16'(k);
            check({tag, "_addr"}, 32'(wr_addr[base + k]), 32'(k));
            check({tag, "_data"}, 32'(wr_data[base + k]), {8'd0, kk[7:0], kk[15:8], 8'hA5});
        end
        check({tag, "_done_cnt"}, 32'(done_cnt - db), 32'd1);
        check({tag, "_busy_at_done"}, 32'(done_busy), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        check({tag, "_csum_err"}, 32'(done_cerr), 32'd0);
`else
        check({tag, "_done_with_we"}, 32'(done_we), 32'd1);
        check({tag, "_done_addr"}, 32'(done_addr), 32'(FP - 1));
`endif
    endtask

    initial begin
        int base, db, sb;

        settle(2);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_soferr", 32'(sof_err), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        settle(1);

        // reset mid-frame after 5 bytes (pixel 0 written, pixel 1 partial)
        db = done_cnt;
        send(8'h10, 1'b1, 1'b0);
        send(8'h20, 1'b0, 1'b0);
        send(8'h30, 1'b0, 1'b0);
        send(8'h40, 1'b0, 1'b0);
        send(8'h50, 1'b0, 1'b0);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_wdata_pre", 32'(mem_wdata), 32'h102030);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_wdata", 32'(mem_wdata), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_we", 32'(mem_we), 32'd0);
        settle(1);
        rst = 1'b0;
        settle(2);
        check("mid_rst_no_done", 32'(done_cnt - db), 32'd0);

        // non-SOF bytes in IDLE are dropped, then a full continuous frame
        base = wr_addr.size();
        for (int i = 0; i < 10; i++) send(8'(8'hC0 + i), 1'b0, 1'b0);
        settle(2);
        check("junk_writes", 32'(wr_addr.size() - base), 32'd0);
        check("junk_busy", 32'(busy), 32'd0);
        db = done_cnt;
        send_frame(1'b0);
        // bytes arriving with/after frame_done need SOF
        send(8'h01, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0);
        settle(3);
        check_frame("cont", base, db);

        // SOF on 2nd byte of pixel 10
        base = wr_addr.size();
        sb = sof_cnt;
        for (int k = 0; k < 10; k++) begin
            send(8'(k), k == 0, 1'b0);
            send(8'h00, 1'b0, 1'b0);
            send(8'hA5, 1'b0, 1'b0);
        end
        send(8'h0A, 1'b0, 1'b0);
        send(8'h77, 1'b1, 1'b0);
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        settle(3);
        check("sof_nwrites", 32'(wr_addr.size() - base), 32'd11);
        check("sof_pix9_addr", 32'(wr_addr[base + 9]), 32'd9);
        check("sof_restart_addr", 32'(wr_addr[base + 10]), 32'd0);
        check("sof_restart_data", 32'(wr_data[base + 10]), 32'h771122);
        check("sof_err_cycles", 32'(sof_cnt - sb), 32'd1);
        check("sof_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        settle(1);
        rst = 1'b0;
        settle(1);

        // load_en toggling with s_valid held high
        base = wr_addr.size();
        db = done_cnt;
        send_frame(1'b1);
        settle(3);
        check_frame("rnd", base, db);

`ifdef LOADER_CHECKSUM_EN
        for (int pass = 0; pass < 2; pass++) begin
            db = done_cnt;
            for (int i = 0; i < 3 * FP; i++) send(8'h01, i == 0, 1'b0);
            send(pass == 0 ? 8'h60 : 8'h61, 1'b0, 1'b0);
            settle(3);
            check("csum_done", 32'(done_cnt - db), 32'd1);
            check("csum_err", 32'(done_cerr), 32'(pass));
            check("csum_busy", 32'(busy), 32'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
